// File: rtl/pulse_desc_fifo_mc_if.sv
// Bundle of write, pop, flush and status signals for pulse_desc_fifo_mc.
// master drives descriptors and strobes; slave is the queue itself.
interface pulse_desc_fifo_mc_if #(
    parameter int DW  = 44,
    parameter int AW  = 4,
    parameter int NCH = 4
);
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic                   wr_en;
    logic [CW-1:0]          wr_ch;
    logic [DW-1:0]          wr_data;
    logic [NCH-1:0]         rd_en;
    logic [NCH*DW-1:0]      rd_data;
    logic [NCH-1:0]         empty;
    logic [NCH-1:0]         full;
    logic [NCH-1:0]         almost_full;
    logic [NCH*(AW+1)-1:0]  count;
    logic [NCH-1:0]         flush;
    logic                   clr_err;
    logic [NCH-1:0]         overflow;
    logic [NCH-1:0]         underflow;

    modport master (
        output wr_en, wr_ch, wr_data, rd_en, flush, clr_err,
        input  rd_data, empty, full, almost_full, count,
        input  overflow, underflow
    );

    modport slave (
        input  wr_en, wr_ch, wr_data, rd_en, flush, clr_err,
        output rd_data, empty, full, almost_full, count,
        output overflow, underflow
    );
endinterface

// File: rtl/pulse_desc_fifo_mc.sv
// Multi-channel FWFT pulse descriptor queue: one steered write port,
// NCH independently drained queues sharing one storage array.
module pulse_desc_fifo_mc #(
    parameter int DW       = 44,
    parameter int AW       = 4,
    parameter int NCH      = 4,
    parameter int AF_LEVEL = (1 << AW) - 2
) (
    input logic                clk,
    input logic                rst,
    pulse_desc_fifo_mc_if.slave bus
);
    localparam int DEPTH = 1 << AW;
    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MW    = $clog2(NCH * DEPTH);

    logic [DW-1:0]        mem [NCH*DEPTH];
    logic [NCH-1:0][AW:0] wr_ptr;
    logic [NCH-1:0][AW:0] rd_ptr;
    logic [NCH-1:0][AW:0] cnt;
    logic [NCH-1:0]       emp;
    logic [NCH-1:0]       ful;
    logic [NCH-1:0]       wr_hit;
    logic [NCH-1:0]       wr_acc;
    logic [NCH-1:0]       rd_acc;
    logic [NCH-1:0]       ovf_set;
    logic [NCH-1:0]       udf_set;
    logic [NCH-1:0]       ovf;
    logic [NCH-1:0]       udf;
    logic [MW-1:0]        waddr;

    // Flush discards same-cycle traffic on its channel, errors included
    always_comb begin
        waddr = '0;
        for (int c = 0; c < NCH; c++) begin
            cnt[c]     = wr_ptr[c] - rd_ptr[c];
            emp[c]     = (cnt[c] == '0);
            ful[c]     = (cnt[c] == (AW+1)'(DEPTH));
            wr_hit[c]  = bus.wr_en && (bus.wr_ch == CW'(c));
            wr_acc[c]  = wr_hit[c] && !ful[c] && !bus.flush[c];
            rd_acc[c]  = bus.rd_en[c] && !emp[c] && !bus.flush[c];
            ovf_set[c] = wr_hit[c] && ful[c] && !bus.flush[c];
            udf_set[c] = bus.rd_en[c] && emp[c] && !bus.flush[c];
            if (wr_acc[c])
                waddr = MW'(c * DEPTH) + MW'(wr_ptr[c][AW-1:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (|wr_acc)
            mem[waddr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= '0;
            udf    <= '0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (bus.flush[c]) begin
                    wr_ptr[c] <= '0;
                    rd_ptr[c] <= '0;
                end else begin
                    if (wr_acc[c])
                        wr_ptr[c] <= wr_ptr[c] + 1'b1;
                    if (rd_acc[c])
                        rd_ptr[c] <= rd_ptr[c] + 1'b1;
                end
                // A new error outranks a same-cycle clear
                if (ovf_set[c])
                    ovf[c] <= 1'b1;
                else if (bus.clr_err)
                    ovf[c] <= 1'b0;
                if (udf_set[c])
                    udf[c] <= 1'b1;
                else if (bus.clr_err)
                    udf[c] <= 1'b0;
            end
        end
    end

    assign bus.empty     = emp;
    assign bus.full      = ful;
    assign bus.overflow  = ovf;
    assign bus.underflow = udf;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [MW-1:0] raddr;
        assign raddr = MW'(c * DEPTH) + MW'(rd_ptr[c][AW-1:0]);
        assign bus.almost_full[c] = (cnt[c] >= (AW+1)'(AF_LEVEL));
        assign bus.count[c*(AW+1) +: AW+1] = cnt[c];
        assign bus.rd_data[c*DW +: DW] = emp[c] ? '0 : mem[raddr];
    end
endmodule

// File: tb/tb_pulse_desc_fifo_mc.sv
// Randomized and directed bench for pulse_desc_fifo_mc against a
// queue-based model of each channel.
module tb_pulse_desc_fifo_mc;
    localparam int DW  = 44;
    localparam int AW  = 4;
    localparam int NCH = 4;
    localparam int DEP = 16;
    localparam int AFL = 14;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    bit   chk_en = 1'b0;

    pulse_desc_fifo_mc_if #(.DW(DW), .AW(AW), .NCH(NCH)) bus ();

    pulse_desc_fifo_mc #(.DW(DW), .AW(AW), .NCH(NCH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] q [NCH][$];
    bit            m_ovf [NCH];
    bit            m_udf [NCH];

    task automatic chk(input string nm, input int c,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s ch%0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    // Model: each channel is a bounded queue; rules applied to pre-edge state
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                q[c].delete();
                m_ovf[c] = 1'b0;
                m_udf[c] = 1'b0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                bit wh, rh, was_full, was_empty, os, us;
                wh = bus.wr_en && (int'(bus.wr_ch) == c);
                rh = bus.rd_en[c];
                was_full = (q[c].size() == DEP);
                was_empty = (q[c].size() == 0);
                os = 1'b0;
                us = 1'b0;
                if (bus.flush[c]) begin
                    q[c].delete();
                end else begin
                    os = wh && was_full;
                    us = rh && was_empty;
                    if (rh && !was_empty) void'(q[c].pop_front());
                    if (wh && !was_full) q[c].push_back(bus.wr_data);
                end
                if (os) m_ovf[c] = 1'b1;
                else if (bus.clr_err) m_ovf[c] = 1'b0;
                if (us) m_udf[c] = 1'b1;
                else if (bus.clr_err) m_udf[c] = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int c = 0; c < NCH; c++) begin
                int n;
                logic [DW-1:0] hd;
                n = q[c].size();
                hd = (n > 0) ? q[c][0] : '0;
                chk("count", c, 64'(bus.count[c*(AW+1) +: AW+1]), 64'(n));
                chk("empty", c, 64'(bus.empty[c]), 64'(n == 0));
                chk("full", c, 64'(bus.full[c]), 64'(n == DEP));
                chk("almost_full", c, 64'(bus.almost_full[c]), 64'(n >= AFL));
                chk("rd_data", c, 64'(bus.rd_data[c*DW +: DW]), 64'(hd));
                chk("overflow", c, 64'(bus.overflow[c]), 64'(m_ovf[c]));
                chk("underflow", c, 64'(bus.underflow[c]), 64'(m_udf[c]));
            end
        end
    end

    task automatic idle();
        bus.wr_en = 1'b0;
        bus.wr_ch = '0;
        bus.wr_data = '0;
        bus.rd_en = '0;
        bus.flush = '0;
        bus.clr_err = 1'b0;
    endtask

    // Present one cycle of inputs, return 1 time unit after the edge
    task automatic op(input logic we, input logic [1:0] ch,
                      input logic [DW-1:0] d, input logic [3:0] rd,
                      input logic [3:0] fl, input logic ce);
        bus.wr_en = we;
        bus.wr_ch = ch;
        bus.wr_data = d;
        bus.rd_en = rd;
        bus.flush = fl;
        bus.clr_err = ce;
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic logic [4:0] cnt_of(input int c);
        return bus.count[c*(AW+1) +: AW+1];
    endfunction

    function automatic logic [DW-1:0] rd_of(input int c);
        return bus.rd_data[c*DW +: DW];
    endfunction

    initial begin
        idle();
        chk_en = 1'b1;
        #12;
        chk("rst_empty", 0, 64'(bus.empty), 64'hF);
        chk("rst_count", 0, 64'(bus.count), 64'h0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        op(1, 2'd1, 44'hA5, 4'b0, 4'b0, 0);
        chk("t1_empty", 1, 64'(bus.empty), 64'hD);
        chk("t1_count", 1, 64'(cnt_of(1)), 64'd1);
        chk("t1_rd", 1, 64'(rd_of(1)), 64'hA5);
        chk("t1_rd0", 0, 64'(rd_of(0)), 64'h0);
        op(0, 2'd0, '0, 4'b0010, 4'b0, 0);

        for (int k = 1; k <= DEP; k++) begin
            op(1, 2'd0, 44'(k - 1), 4'b0, 4'b0, 0);
            chk("t2_af", k, 64'(bus.almost_full[0]), 64'(k >= 14));
            chk("t2_full", k, 64'(bus.full[0]), 64'(k == 16));
        end
        op(1, 2'd0, 44'h3FF, 4'b0, 4'b0, 0);
        chk("t2_ovf", 0, 64'(bus.overflow[0]), 64'd1);
        chk("t2_cnt", 0, 64'(cnt_of(0)), 64'd16);
        for (int k = 0; k < DEP; k++) begin
            chk("t2_drain", k, 64'(rd_of(0)), 64'(k));
            op(0, 2'd0, '0, 4'b0001, 4'b0, 0);
        end
        chk("t2_empty", 0, 64'(bus.empty[0]), 64'd1);
        op(0, 2'd0, '0, 4'b0, 4'b0, 1);
        chk("t2_clr", 0, 64'(bus.overflow[0]), 64'd0);

        op(1, 2'd2, 44'd100, 4'b0, 4'b0, 0);
        for (int k = 0; k < 40; k++) begin
            chk("t3_head", k, 64'(rd_of(2)), 64'(100 + k));
            op(1, 2'd2, 44'(101 + k), 4'b0100, 4'b0, 0);
            chk("t3_cnt", k, 64'(cnt_of(2)), 64'd1);
        end
        chk("t3_flags", 2, 64'({bus.overflow, bus.underflow}), 64'h0);
        op(0, 2'd0, '0, 4'b0100, 4'b0, 0);

        op(1, 2'd3, 44'h7, 4'b1000, 4'b0, 0);
        chk("t4_udf", 3, 64'(bus.underflow[3]), 64'd1);
        chk("t4_cnt", 3, 64'(cnt_of(3)), 64'd1);
        chk("t4_rd", 3, 64'(rd_of(3)), 64'h7);
        op(0, 2'd0, '0, 4'b0, 4'b0, 1);
        chk("t4_clr", 3, 64'(bus.underflow[3]), 64'd0);
        op(0, 2'd0, '0, 4'b1000, 4'b0, 0);

        op(1, 2'd0, 44'h11, 4'b0, 4'b0, 0);
        op(1, 2'd0, 44'h22, 4'b0, 4'b0, 0);
        for (int k = 0; k < 5; k++)
            op(1, 2'd1, 44'(k + 1), 4'b0, 4'b0, 0);
        op(1, 2'd1, 44'h99, 4'b0001, 4'b0010, 0);
        chk("t5_cnt", 1, 64'(cnt_of(1)), 64'd0);
        chk("t5_empty", 1, 64'(bus.empty[1]), 64'd1);
        chk("t5_ovf", 1, 64'(bus.overflow[1]), 64'd0);
        chk("t5_cnt0", 0, 64'(cnt_of(0)), 64'd1);
        chk("t5_rd0", 0, 64'(rd_of(0)), 64'h22);
        op(0, 2'd0, '0, 4'b0, 4'b0001, 0);

        for (int p = 0; p < 4; p++) begin
            int rdp;
            rdp = (p == 0) ? 20 : (p == 1) ? 45 : (p == 2) ? 70 : 30;
            for (int n = 0; n < 500; n++) begin
                logic [3:0] rd, fl;
                for (int c = 0; c < NCH; c++) begin
                    rd[c] = ($urandom_range(0, 99) < rdp);
                    fl[c] = ($urandom_range(0, 63) == 0);
                end
                op($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
                   {12'($urandom), 32'($urandom)}, rd, fl,
                   $urandom_range(0, 15) == 0);
            end
        end

        for (int n = 0; n < 30; n++)
            op(1, 2'(n % 4), 44'(n), 4'($urandom), 4'b0, 0);
        bus.wr_en = 1'b1;
        bus.wr_ch = 2'd2;
        bus.wr_data = 44'h5;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("t6_empty", 0, 64'(bus.empty), 64'hF);
        chk("t6_count", 0, 64'(bus.count), 64'h0);
        chk("t6_flags", 0,
            64'({bus.full, bus.almost_full, bus.overflow, bus.underflow}), 64'h0);
        chk("t6_rd", 0, 64'(bus.rd_data), 64'h0);
        idle();
        @(negedge clk);
        #2 rst = 1'b0;
        op(1, 2'd0, 44'h1234, 4'b0, 4'b0, 0);
        chk("t6_after", 0, 64'(rd_of(0)), 64'h1234);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
